data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_store.sv | 45 ++++
 rtl/data_cache.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
// Holds the controller state encoding and the default geometry.
package cache_pkg;

  localparam int DEFAULT_INDEX_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RFILL = 2'd1,
    WBUSY = 2'd2,
    WDONE = 2'd3
  } cache_state_t;

endpackage

// File: rtl/cache_store.sv
// Tag/data/valid storage for the data cache: one word per line,
// combinational read port, synchronous write port, valid bits cleared by rst.
module cache_store #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays are deliberately left unreset; valid guards them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with zero-cycle
// read hits. Handshake: MEM_REQ stays high with stable MEM_ADDR/MEM_WE/MEM_WDATA
// until the one-cycle MEM_ACK pulse; HIT=0 stalls the pipeline, which holds its inputs.
module data_cache
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int TAG_BITS   = 32 - 2 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  output logic        HIT,
  output logic [31:0] READ_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  cache_state_t state, state_next;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [31:0]           word_addr;
  logic                  unused_addr_bits;

  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_data;
  logic                  lookup_hit;
  logic                  store_we;
  logic [31:0]           store_wdata;

  assign index            = ADDRESS[INDEX_BITS+1:2];
  assign tag              = ADDRESS[31:INDEX_BITS+2];
  assign word_addr        = {ADDRESS[31:2], 2'b00};
  assign unused_addr_bits = ^ADDRESS[1:0];
  assign lookup_hit       = line_valid && (line_tag == tag);

  cache_store #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_index(index),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (store_we),
    .wr_index(index),
    .wr_tag  (tag),
    .wr_data (store_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are gated by rst so an abandoned transaction drops MEM_REQ at once.
  always_comb begin
    state_next  = state;
    HIT         = 1'b0;
    READ_DATA   = '0;
    MEM_REQ     = 1'b0;
    MEM_WE      = 1'b0;
    MEM_ADDR    = '0;
    MEM_WDATA   = '0;
    store_we    = 1'b0;
    store_wdata = MEM_RDATA;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (MEM_WRITE) begin
            state_next = WBUSY;
          end else if (MEM_READ) begin
            if (lookup_hit) begin
              HIT       = 1'b1;
              READ_DATA = line_data;
            end else begin
              state_next = RFILL;
            end
          end else begin
            HIT = 1'b1;
          end
        end
        RFILL: begin
          MEM_REQ  = 1'b1;
          MEM_ADDR = word_addr;
          if (MEM_ACK) begin
            store_we   = 1'b1;
            state_next = IDLE;
          end
        end
        WBUSY: begin
          MEM_REQ   = 1'b1;
          MEM_WE    = 1'b1;
          MEM_ADDR  = word_addr;
          MEM_WDATA = WRITE_DATA;
          if (MEM_ACK) begin
            // No allocate: only a line already holding this address is refreshed.
            store_we    = lookup_hit;
            store_wdata = WRITE_DATA;
            state_next  = WDONE;
          end
        end
        WDONE: begin
          HIT        = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
